fft_logpwr: RTL and testbench
=============================

Name: fft_logpwr

Overview:
- Streaming stage directly upstream of the false-color colormap.
- Takes complex FFT output bins (real/imag) and computes power = re² + im².
- Converts power to an 8-bit log2 pixel index (1/8-octave resolution, about 0.376 dB per LSB) that feeds the colormap's pixel input.
- Four-stage pipeline with valid/ready flow control and frame-boundary (last) pass-through.

Parameters:
- IW, 16, signed width of each input component; legal range 4..16 so the exponent fits in 5 bits.

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_areset_n  input  1  asynchronous active-low reset
- i_valid  input  1  input bin valid
- o_ready  output  1  block can accept input this cycle
- i_real  input  IW  signed real part of FFT bin
- i_imag  input  IW  signed imaginary part of FFT bin
- i_last  input  1  marks final bin of an FFT frame
- o_valid  output  1  output pixel valid
- i_ready  input  1  downstream accepts pixel this cycle
- o_pixel  output  8  log-power pixel index {exponent[4:0], fraction[2:0]}
- o_last  output  1  last flag aligned with o_pixel

Behaviour:
- Clock and reset: one clock i_clk; reset i_areset_n is asynchronous, active-low.
- Reset assertion (async) clears all stage valids, data, and last flags immediately:
  - o_valid=0, o_pixel=8'h00, o_last=0.
  - o_ready=1 one cycle after reset is released.
- Reset mid-frame discards all in-flight bins. No partial-frame recovery.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - While o_valid && !i_ready, o_pixel and o_last are held stable.
- Pipeline advance:
  - ce = !o_valid || i_ready; o_ready = ce (combinational).
  - Whole pipeline moves together on ce. Bubbles propagate but are not squeezed.
- Latency: an accepted bin appears on o_valid exactly 4 cycles later when there is no backpressure. Throughput is 1 bin per clock.
- Stage 1: register re² and im² separately. Each is unsigned, 2*IW-1 bits; (-2^(IW-1))² = 2^(2IW-2) must be exact.
- Stage 2: power P = re² + im², unsigned 2*IW bits. No saturation is needed; max P = 2^(2IW-1).
- Stage 3: leading-one detect on P.
  - E = index of MSB set (0..2IW-1).
  - F = the 3 bits immediately below the MSB. Bit positions below 0 read as 0, so E<3 gives F zero-padded on the right.
  - Also register zero flag Z = (P==0).
- Stage 4: o_pixel = Z ? 8'h00 : {E[4:0], F[2:0]}. P=0 and P=1 both give 8'h00, which is intended.
- For IW=16, o_pixel range is 0x00..0xF8; values above 0xF8 are never produced.
- Monotonic: P1 ≤ P2 implies pixel(P1) ≤ pixel(P2).
- i_last travels with its bin through all 4 stages. o_last=1 only on the pixel of a bin accepted with i_last=1.
- Simultaneous in/out with a full pipeline and i_ready=1: accept and emit in the same cycle, no loss.
- i_valid=0 with ce=1 inserts a bubble; the stage valid is cleared and data may be don't-care, but o_pixel must read 8'h00 whenever o_valid=0.
- Signed inputs: the sign of re and im never affects the output, e.g. (-3,4) ≡ (3,-4) ≡ (3,4).

Test Plan:
- Reset then single bins with i_ready=1, checked 4 cycles later:
  - (0,0) -> 0x00
  - (1,0) -> 0x00
  - (16,0) -> 0x40
  - (3,4), P=25 -> 0x24
  - (-32768,0) -> 0xF0
  - (-32768,-32768) -> 0xF8
- Continuous stream of 64 bins with i_last on bin 63, i_ready=1 -> 64 back-to-back o_valid cycles starting 4 cycles after first accept; o_last=1 only on the 64th; values match the reference model.
- Backpressure: stream 20 bins with i_ready toggling pseudo-randomly -> no drop or duplicate; o_pixel/o_last stable while stalled; o_ready=0 exactly when o_valid && !i_ready.
- Bubbles: i_valid asserted every third cycle -> o_valid pattern identical, shifted by 4 cycles; o_pixel=0x00 in gaps.
- Async reset asserted mid-stream with 3 bins in flight -> o_valid falls immediately without a clock edge; no stale pixel appears after release; the next bin after release has correct latency.
- Monotonic sweep: re=0..1023, im=0 -> o_pixel non-decreasing, exactly matching {E,F} for each re².

Source files
------------

// File: rtl/fft_logpwr.sv
// Streaming log-power stage: complex FFT bin -> 8-bit log2 pixel index
// {exponent[4:0], fraction[2:0]}, four registered stages with valid/ready and frame-last pass-through.
module fft_logpwr #(
    parameter int IW = 16
) (
    input  logic          i_clk,
    input  logic          i_areset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [IW-1:0] i_real,
    input  logic [IW-1:0] i_imag,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [7:0]    o_pixel,
    output logic          o_last
);
    localparam int PW = 2 * IW;

    // Handshake: input transfers on i_valid && o_ready, output transfers on
    // o_valid && i_ready. The whole pipeline advances together on ce; while
    // o_valid && !i_ready everything, including o_pixel/o_last, holds.
    logic ce;
    assign ce      = !o_valid || i_ready;
    assign o_ready = ce;

    logic [IW-1:0] mag_re, mag_im;
    logic [PW-2:0] ext_re, ext_im;
    logic [PW-2:0] sq_re_next, sq_im_next;

    // Magnitude is taken first so -2^(IW-1) squares exactly in PW-1 unsigned bits.
    always_comb begin
        mag_re     = i_real[IW-1] ? ((~i_real) + IW'(1)) : i_real;
        mag_im     = i_imag[IW-1] ? ((~i_imag) + IW'(1)) : i_imag;
        ext_re     = (PW-1)'(mag_re);
        ext_im     = (PW-1)'(mag_im);
        sq_re_next = ext_re * ext_re;
        sq_im_next = ext_im * ext_im;
    end

    logic          v1, v2, v3;
    logic          l1, l2, l3;
    logic [PW-2:0] sq_re, sq_im;
    logic [PW-1:0] pwr;
    logic [4:0]    exp3;
    logic [2:0]    frac3;
    logic          zero3;

    logic [4:0]    msb;
    logic [PW+2:0] shifted;
    logic [2:0]    frac_next;

    // Leading-one detect; shifting {P,000} right by the MSB index leaves the
    // three bits below the MSB (zero-padded when MSB < 3) in the low bits.
    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < PW; i++) begin
            if (pwr[i]) msb = 5'(i);
        end
        shifted   = {pwr, 3'b000} >> msb;
        frac_next = shifted[2:0];
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            o_valid <= 1'b0;
            l1      <= 1'b0;
            l2      <= 1'b0;
            l3      <= 1'b0;
            o_last  <= 1'b0;
            sq_re   <= '0;
            sq_im   <= '0;
            pwr     <= '0;
            exp3    <= 5'd0;
            frac3   <= 3'd0;
            zero3   <= 1'b1;
            o_pixel <= 8'h00;
        end else if (ce) begin
            v1      <= i_valid;
            l1      <= i_valid && i_last;
            sq_re   <= sq_re_next;
            sq_im   <= sq_im_next;

            v2      <= v1;
            l2      <= l1;
            pwr     <= PW'(sq_re) + PW'(sq_im);

            v3      <= v2;
            l3      <= l2;
            exp3    <= msb;
            frac3   <= frac_next;
            zero3   <= (pwr == '0);

            // Bubbles always present a zero pixel.
            o_valid <= v3;
            o_last  <= v3 && l3;
            o_pixel <= (v3 && !zero3) ? {exp3, frac3} : 8'h00;
        end
    end
endmodule

// File: tb/tb_fft_logpwr.sv
// Self-checking bench for fft_logpwr: directed bins, streams, backpressure,
// bubbles, async reset and a monotonic sweep against a power/log2 model.
module tb_fft_logpwr;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic signed [15:0] i_real = '0;
    logic signed [15:0] i_imag = '0;
    logic               i_last = 1'b0;
    logic               o_valid;
    logic               i_ready = 1'b1;
    logic [7:0]         o_pixel;
    logic               o_last;

    fft_logpwr #(.IW(16)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_real     (i_real),
        .i_imag     (i_imag),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_pixel    (o_pixel),
        .o_last     (o_last)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference: power by plain arithmetic, pixel = floor(log2 P) and the
    // next three binary digits of P below its leading one.
    function automatic logic [7:0] ref_pix(input int re, input int im);
        longint p;
        longint fr;
        int e;
        p = longint'(re) * re + longint'(im) * im;
        if (p == 0) return 8'h00;
        e = 0;
        while ((p >> (e + 1)) != 0) e++;
        fr = ((p << 3) >> e) & 7;
        return {5'(e), 3'(fr)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int         acc_q[$];
    int         dir_exp   = -1;
    bit         lat_check = 1'b1;
    bit         bp_on     = 1'b0;
    bit         mono_on   = 1'b0;
    logic [7:0] mono_prev = 8'h00;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic       prev_last;

    always @(posedge clk) begin
        #1;
        i_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("o_ready_rule", {31'd0, o_ready}, {31'd0, !(o_valid && !i_ready)});
            if (!o_valid) check("pixel_zero_gap", {24'd0, o_pixel}, 32'h0);
            if (prev_stall) begin
                check("stall_valid", {31'd0, o_valid}, 32'd1);
                check("stall_pixel", {24'd0, o_pixel}, {24'd0, prev_pix});
                check("stall_last",  {31'd0, o_last},  {31'd0, prev_last});
            end
            if (i_valid && o_ready) begin
                if (dir_exp >= 0) exp_q.push_back({i_last, dir_exp[7:0]});
                else exp_q.push_back({i_last, ref_pix(int'(i_real), int'(i_imag))});
                acc_q.push_back(cyc);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("pixel", {24'd0, o_pixel}, {24'd0, e[7:0]});
                    check("last",  {31'd0, o_last},  {31'd0, e[8]});
                    if (lat_check) check("latency", cyc - a, 32'd4);
                    if (mono_on) begin
                        check("monotonic", {31'd0, o_pixel >= mono_prev}, 32'd1);
                        mono_prev = o_pixel;
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_pix   = o_pixel;
            prev_last  = o_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int re, input int im, input bit last);
        int budget;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_real  = 16'(re);
        i_imag  = 16'(im);
        i_last  = last;
        budget  = 0;
        @(negedge clk);
        while (!o_ready) begin
            budget++;
            if (budget > 1000) begin
                check("accept_timeout", 32'd1, 32'd0);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        idle(1);
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    int dir_re[6]  = '{0, 1, 16, 3, -32768, -32768};
    int dir_im[6]  = '{0, 0, 0, 4, 0, -32768};
    int dir_px[6]  = '{8'h00, 8'h00, 8'h40, 8'h24, 8'hF0, 8'hF8};

    initial begin
        // Reset state
        #12;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_pixel", {24'd0, o_pixel}, 32'h0);
        check("rst_last",  {31'd0, o_last},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, o_ready}, 32'd1);

        // Directed single bins with fixed expected pixels
        for (int i = 0; i < 6; i++) begin
            dir_exp = dir_px[i];
            send(dir_re[i], dir_im[i], 1'b0);
            idle(1);
            dir_exp = -1;
            idle(5);
        end
        drain();
        // Sign independence
        send(-3, 4, 1'b0);
        send(3, -4, 1'b0);
        send(-3, -4, 1'b0);
        drain();

        // 64-bin back-to-back frame
        for (int i = 0; i < 64; i++) begin
            logic [15:0] r, m;
            r = 16'($urandom);
            m = 16'($urandom_range(0, 255));
            send(int'($signed(r)), int'($signed(m)), i == 63);
        end
        drain();

        // Backpressure
        lat_check = 1'b0;
        bp_on     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] r, m;
            r = 16'($urandom);
            m = 16'($urandom);
            send(int'($signed(r)), int'($signed(m)), i == 19);
        end
        for (int i = 0; i < 150; i++) begin
            logic [15:0] r, m;
            r = 16'($urandom);
            m = 16'($urandom_range(0, 15));
            send(int'($signed(r)) >>> $urandom_range(0, 14), int'($signed(m)), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        bp_on = 1'b0;
        drain();
        lat_check = 1'b1;

        // Bubbles: valid every third cycle
        for (int i = 0; i < 12; i++) begin
            send($urandom_range(0, 4095), $urandom_range(0, 4095), i == 11);
            idle(2);
        end
        drain();

        // Async reset with bins in flight
        for (int i = 0; i < 6; i++) send(100 + i, 7, 1'b0);
        idle(1);
        #1;
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, o_valid}, 32'd0);
        check("async_pixel", {24'd0, o_pixel}, 32'h0);
        check("async_last",  {31'd0, o_last},  32'd0);
        exp_q.delete();
        acc_q.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        check("no_stale_pending", exp_q.size(), 32'd0);
        send(-32768, 0, 1'b1);
        drain();

        // Monotonic sweep re = 0..1023
        mono_on   = 1'b1;
        mono_prev = 8'h00;
        for (int i = 0; i < 1024; i++) send(i, 0, i == 1023);
        drain();
        mono_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
